// File: rtl/vga_seq_pkg.sv
// Package: vga_seq_pkg
// Shared types and the constant pattern table for the VGA pattern sequencer.
//   pat_entry_t : one table entry {r_sel, g_sel, speed, dir}
//   seq_state_t : sequencing mode {MANUAL, AUTO, PAUSED}
//   PAT_TABLE   : eight constant entries; every speed <= 7, r_sel/g_sel <= 9
package vga_seq_pkg;

    typedef struct packed {
        logic [3:0] r_sel;  // bit index of moving_x driven to R[1]
        logic [3:0] g_sel;  // bit index of pix_y driven to G[0]
        logic [2:0] speed;  // scroll step per frame
        logic       dir;    // 0 = scroll forward, 1 = scroll backward
    } pat_entry_t;

    typedef enum logic [1:0] {
        MANUAL = 2'd0,
        AUTO   = 2'd1,
        PAUSED = 2'd2
    } seq_state_t;

    localparam int TABLE_DEPTH = 8;

    localparam pat_entry_t PAT_TABLE [TABLE_DEPTH] = '{
        '{4'd5, 4'd3, 3'd1, 1'b0},
        '{4'd4, 4'd4, 3'd2, 1'b0},
        '{4'd6, 4'd2, 3'd3, 1'b1},
        '{4'd7, 4'd1, 3'd1, 1'b1},
        '{4'd3, 4'd5, 3'd4, 1'b0},
        '{4'd8, 4'd6, 3'd2, 1'b1},
        '{4'd2, 4'd9, 3'd5, 1'b0},
        '{4'd9, 4'd0, 3'd7, 1'b1}
    };

endpackage

// File: rtl/vga_pattern_sequencer_sync_edge_det.sv
// Module: sync_edge_det
// Two-flop synchroniser followed by a registered edge detector.
//   clk    : destination clock
//   rst_n  : asynchronous active-low reset
//   din    : asynchronous input
//   pulse  : one-cycle strobe, high 3 clk after an active edge of din
// POLARITY = 1 detects rising edges, 0 detects falling edges. All flops
// reset to the inactive level so a fresh active edge is required after reset.
module sync_edge_det #(
    parameter logic POLARITY = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic pulse
);

    localparam logic IDLE = ~POLARITY;

    logic s1_q;
    logic s2_q;
    logic prev_q;
    logic pulse_q;
    logic pulse_d;

    always_comb begin
        pulse_d = (s2_q == POLARITY) && (prev_q != POLARITY);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q    <= IDLE;
            s2_q    <= IDLE;
            prev_q  <= IDLE;
            pulse_q <= 1'b0;
        end else begin
            s1_q    <= din;
            s2_q    <= s1_q;
            prev_q  <= s2_q;
            pulse_q <= pulse_d;
        end
    end

    assign pulse = pulse_q;

endmodule

// File: rtl/vga_pattern_sequencer.sv
// Module: vga_pattern_sequencer
// Frame-synchronous sequencer for the VGA test-pattern datapath. Once per
// frame (on frame_tick) it updates the scroll offset and the R/G bit-select
// indices, stepping through PAT_TABLE on a dwell timer (auto) or on step.
//   clk        : pixel clock          rst_n     : async active-low reset
//   vsync_in   : vsync from sync gen  auto_en   : 1 = auto advance (async)
//   pause      : freeze scroll/dwell  step      : advance one entry (async)
//   scroll_x   : horizontal offset    r_sel     : R[1] bit index
//   g_sel      : G[0] bit index       pat_idx   : current table index
//   frame_tick : one-cycle strobe per frame
module vga_pattern_sequencer
    import vga_seq_pkg::*;
#(
    parameter int NUM_PATTERNS      = 8,
    parameter int DWELL_FRAMES      = 120,
    parameter int VSYNC_ACTIVE_HIGH = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       vsync_in,
    input  logic       auto_en,
    input  logic       pause,
    input  logic       step,
    output logic [9:0] scroll_x,
    output logic [3:0] r_sel,
    output logic [3:0] g_sel,
    output logic [2:0] pat_idx,
    output logic       frame_tick
);

    localparam int DW = (DWELL_FRAMES > 1) ? $clog2(DWELL_FRAMES) : 1;
    localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_FRAMES - 1);
    localparam logic [2:0]    IDX_LAST   = 3'(NUM_PATTERNS - 1);

    logic tick;
    logic step_pulse;
    logic [1:0] auto_sync_q;
    logic [1:0] pause_sync_q;

    seq_state_t    state_q, state_d;
    logic [9:0]    scroll_q, scroll_d;
    logic [2:0]    pat_idx_q, pat_idx_d;
    logic [3:0]    r_sel_q, r_sel_d;
    logic [3:0]    g_sel_q, g_sel_d;
    logic [DW-1:0] dwell_q, dwell_d;
    logic          step_pending_q, step_pending_d;
    seq_state_t    mode;
    logic          advance;

    sync_edge_det #(.POLARITY(VSYNC_ACTIVE_HIGH != 0)) u_vsync_det (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (vsync_in),
        .pulse (tick)
    );

    sync_edge_det #(.POLARITY(1'b1)) u_step_det (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (step),
        .pulse (step_pulse)
    );

    always_comb begin
        mode           = state_q;
        advance        = 1'b0;
        state_d        = state_q;
        scroll_d       = scroll_q;
        pat_idx_d      = pat_idx_q;
        r_sel_d        = r_sel_q;
        g_sel_d        = g_sel_q;
        dwell_d        = dwell_q;
        step_pending_d = step_pending_q | step_pulse;

        if (tick) begin
            // Mode is re-sampled every frame; this frame's actions use it.
            if (pause_sync_q[1])      mode = PAUSED;
            else if (auto_sync_q[1])  mode = AUTO;
            else                      mode = MANUAL;
            state_d = mode;

            // Scroll uses the entry in force before any advance this frame.
            if (mode != PAUSED) begin
                if (PAT_TABLE[pat_idx_q].dir)
                    scroll_d = scroll_q - 10'(PAT_TABLE[pat_idx_q].speed);
                else
                    scroll_d = scroll_q + 10'(PAT_TABLE[pat_idx_q].speed);
            end

            advance = step_pending_q || ((mode == AUTO) && (dwell_q == DWELL_LAST));
            // A step edge landing on the tick itself is kept for next frame.
            step_pending_d = step_pulse;

            if (advance) begin
                pat_idx_d = (pat_idx_q == IDX_LAST) ? 3'd0 : pat_idx_q + 3'd1;
                r_sel_d   = PAT_TABLE[pat_idx_d].r_sel;
                g_sel_d   = PAT_TABLE[pat_idx_d].g_sel;
                dwell_d   = '0;
            end else if (mode == AUTO) begin
                dwell_d = dwell_q + DW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            auto_sync_q    <= 2'b00;
            pause_sync_q   <= 2'b00;
            state_q        <= MANUAL;
            scroll_q       <= 10'd0;
            pat_idx_q      <= 3'd0;
            r_sel_q        <= PAT_TABLE[0].r_sel;
            g_sel_q        <= PAT_TABLE[0].g_sel;
            dwell_q        <= '0;
            step_pending_q <= 1'b0;
        end else begin
            auto_sync_q    <= {auto_sync_q[0], auto_en};
            pause_sync_q   <= {pause_sync_q[0], pause};
            state_q        <= state_d;
            scroll_q       <= scroll_d;
            pat_idx_q      <= pat_idx_d;
            r_sel_q        <= r_sel_d;
            g_sel_q        <= g_sel_d;
            dwell_q        <= dwell_d;
            step_pending_q <= step_pending_d;
        end
    end

    assign scroll_x   = scroll_q;
    assign r_sel      = r_sel_q;
    assign g_sel      = g_sel_q;
    assign pat_idx    = pat_idx_q;
    assign frame_tick = tick;

endmodule

// File: tb/tb_vga_pattern_sequencer.sv
module tb_vga_pattern_sequencer;

    localparam int NP = 3;
    localparam int DF = 4;

    logic       clk;
    logic       rst_n;
    logic       vsync_in;
    logic       auto_en;
    logic       pause;
    logic       step;
    logic [9:0] scroll_x;
    logic [3:0] r_sel;
    logic [3:0] g_sel;
    logic [2:0] pat_idx;
    logic       frame_tick;

    vga_pattern_sequencer #(
        .NUM_PATTERNS      (NP),
        .DWELL_FRAMES      (DF),
        .VSYNC_ACTIVE_HIGH (0)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .vsync_in   (vsync_in),
        .auto_en    (auto_en),
        .pause      (pause),
        .step       (step),
        .scroll_x   (scroll_x),
        .r_sel      (r_sel),
        .g_sel      (g_sel),
        .pat_idx    (pat_idx),
        .frame_tick (frame_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string name, input int act, input int exp_v);
        n_checks++;
        if (act != exp_v) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp_v, $time);
        end
    endtask

    // Reference table entries 0..2 (only these are reachable with NP=3).
    int t_r   [3] = '{5, 4, 6};
    int t_g   [3] = '{3, 4, 2};
    int t_spd [3] = '{1, 2, 3};
    int t_dir [3] = '{0, 0, 1};

    // Behavioural model state.
    int  m_scroll = 0;
    int  m_idx    = 0;
    int  m_dwell  = 0;
    bit  m_pend   = 0;

    typedef struct {
        int cyc;
        int scroll;
        int idx;
        int r;
        int g;
    } exp_t;

    exp_t q[$];

    task automatic model_tick(input bit a, input bit p, input int tick_cyc);
        exp_t e;
        bit adv;
        if (!p) begin
            if (t_dir[m_idx] != 0) m_scroll = (m_scroll - t_spd[m_idx] + 1024) % 1024;
            else                   m_scroll = (m_scroll + t_spd[m_idx]) % 1024;
        end
        adv = m_pend || (!p && a && m_dwell == DF - 1);
        m_pend = 0;
        if (adv) begin
            m_idx   = (m_idx + 1) % NP;
            m_dwell = 0;
        end else if (!p && a) begin
            m_dwell++;
        end
        e.cyc    = tick_cyc;
        e.scroll = m_scroll;
        e.idx    = m_idx;
        e.r      = t_r[m_idx];
        e.g      = t_g[m_idx];
        q.push_back(e);
    endtask

    // One frame: set mode, issue step pulses, then a vsync falling edge.
    task automatic frame(input bit a, input bit p, input int nsteps);
        @(negedge clk);
        auto_en = a;
        pause   = p;
        for (int i = 0; i < nsteps; i++) begin
            step = 1'b1;
            repeat (4) @(negedge clk);
            step = 1'b0;
            repeat (4) @(negedge clk);
        end
        if (nsteps > 0) m_pend = 1;
        repeat (6) @(negedge clk);
        model_tick(a, p, cyc + 3);
        vsync_in = 1'b0;
        repeat (6) @(negedge clk);
        vsync_in = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    // Monitor: on each frame_tick, pop the expected frame and compare the
    // outputs on the following cycle, after the tick has taken effect.
    exp_t cur;
    bit   cmp_pend = 0;
    always @(negedge clk) begin
        if (cmp_pend) begin
            cmp_pend = 0;
            check("scroll_x",   int'(scroll_x), cur.scroll);
            check("pat_idx",    int'(pat_idx),  cur.idx);
            check("r_sel",      int'(r_sel),    cur.r);
            check("g_sel",      int'(g_sel),    cur.g);
            check("tick_width", int'(frame_tick), 0);
        end
        if (rst_n && frame_tick) begin
            if (q.size() == 0) begin
                check("unexpected_tick", 1, 0);
            end else begin
                cur = q.pop_front();
                check("tick_latency", cyc, cur.cyc);
                cmp_pend = 1;
            end
        end
    end

    task automatic check_reset_values(input string tag);
        check({tag, "_scroll"}, int'(scroll_x), 0);
        check({tag, "_idx"},    int'(pat_idx),  0);
        check({tag, "_r"},      int'(r_sel),    5);
        check({tag, "_g"},      int'(g_sel),    3);
        check({tag, "_tick"},   int'(frame_tick), 0);
    endtask

    initial begin
        rst_n    = 1'b0;
        vsync_in = 1'b1;
        auto_en  = 1'b0;
        pause    = 1'b0;
        step     = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_values("reset");
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // Auto mode, five frames: advance on frame 4.
        for (int i = 0; i < 5; i++) frame(1'b1, 1'b0, 0);
        // Pause for three frames, then resume auto.
        for (int i = 0; i < 3; i++) frame(1'b1, 1'b1, 0);
        frame(1'b1, 1'b0, 0);
        // Manual: three steps collapse to one advance, then a quiet frame.
        frame(1'b0, 1'b0, 3);
        frame(1'b0, 1'b0, 0);
        // Single-step while paused; scroll must not move.
        frame(1'b0, 1'b1, 1);
        // Walk the reverse-scrolling entry through wrap and index wrap.
        for (int i = 0; i < 6; i++) frame(1'b0, 1'b0, (i % 2));

        // Asynchronous reset mid-cycle; no tick may follow without a new edge.
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_reset_values("async_reset");
        m_scroll = 0; m_idx = 0; m_dwell = 0; m_pend = 0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        frame(1'b1, 1'b0, 0);

        // Randomised frames.
        for (int i = 0; i < 50; i++)
            frame(1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
                  int'($urandom_range(0, 2)));

        repeat (20) @(negedge clk);
        check("queue_empty", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/vga_pattern_sequencer.md
Name: vga_pattern_sequencer

Overview:
Frame-synchronous controller that sequences the VGA test-pattern datapath. Per frame it supplies the horizontal scroll offset and the R/G bit-select indices the pattern generator consumes, stepping through a constant pattern table automatically (dwell timer) or manually (step button). It sits between the board inputs and the pattern datapath, clocked on the pixel clock and driven by the sync generator's vsync. The datapath is never clocked from vsync.

Parameters:
NUM_PATTERNS, 8, table entries used; pat_idx wraps at NUM_PATTERNS-1.
DWELL_FRAMES, 120, frames per entry in auto mode (>=1).
VSYNC_ACTIVE_HIGH, 0, polarity of vsync_in; 0 means the active edge is falling.

Ports:
clk  input  1  pixel clock
rst_n  input  1  reset; asynchronous, active-low
vsync_in  input  1  vsync from sync generator
auto_en  input  1  1 = auto advance, 0 = manual; asynchronous
pause  input  1  freeze scroll and dwell; asynchronous
step  input  1  advance one entry; asynchronous, rising edge
scroll_x  output  10  horizontal scroll offset added to pix_x
r_sel  output  4  bit index of moving_x driven to R[1]
g_sel  output  4  bit index of pix_y driven to G[0]
pat_idx  output  3  current table index
frame_tick  output  1  one-cycle strobe per frame

Behaviour:
- The only clock is clk; reset is asynchronous and active-low, named rst_n.
- Reset values: scroll_x=0, pat_idx=0, r_sel/g_sel=PAT_TABLE[0] fields, frame_tick=0, dwell=0, step_pending=0, state=MANUAL.
- vsync_in, step, auto_en and pause each pass through a 2-FF synchroniser.
- frame_tick is high exactly 3 clk after the active edge of vsync_in (2 sync stages + edge register). It lasts one cycle.
- step rising edge (post-sync) sets step_pending. Any number of edges between two ticks collapses to one advance. step_pending clears on the tick that consumes it.
- Every output changes only on a frame_tick cycle, so there is no mid-frame tearing.
- State (evaluated on frame_tick only, from synced auto_en/pause sampled that cycle): PAUSED if pause=1; else AUTO if auto_en=1; else MANUAL. The state register updates on the tick; the actions below use the newly sampled mode.
- On each frame_tick:
  - Scroll (AUTO/MANUAL only): scroll_x += speed if dir=0, -= speed if dir=1, using the entry current before any advance. Arithmetic is modulo 1024 and wraps silently.
  - Advance condition: step_pending, OR (AUTO and dwell==DWELL_FRAMES-1).
  - On advance: pat_idx = (pat_idx==NUM_PATTERNS-1) ? 0 : pat_idx+1; r_sel/g_sel reload from the new entry; dwell=0.
  - Without advance: dwell increments in AUTO, holds in MANUAL/PAUSED.
  - PAUSED: scroll_x and dwell hold. A pending step still advances the entry (single-step while frozen).
- Leaving AUTO for MANUAL keeps the dwell value. Re-entering AUTO resumes the count.
- Reset asserted mid-frame returns all outputs to reset values immediately. The first tick after release needs a fresh vsync active edge, because the edge detector resets to the inactive level.
- No activity on vsync means no ticks, and all outputs hold.

Decomposition:
- Package vga_seq_pkg:
  - pat_entry_t {r_sel[3:0], g_sel[3:0], speed[2:0], dir}.
  - seq_state_t {MANUAL, AUTO, PAUSED}.
  - Constant PAT_TABLE[0:7]. Entries 0-2 are fixed: 0={5,3,1,0}, 1={4,4,2,0}, 2={6,2,3,1}. Entries 3-7 are free, with speed<=7 and r_sel/g_sel<=9.
- One sub-module: sync_edge_det (2-FF synchroniser + registered edge detector, POLARITY parameter). It is instanced for vsync_in and for step.

Test Plan:
- Reset mid-run with scroll_x=37, pat_idx=2: assert rst_n=0 without a clock edge -> scroll_x=0, pat_idx=0, r_sel=5, g_sel=3 immediately; the next tick requires a new vsync falling edge.
- DWELL_FRAMES=4, auto_en=1, 5 vsync pulses -> after tick 4: scroll_x=4, pat_idx=1, r_sel=4, g_sel=4; after tick 5: scroll_x=6; frame_tick lands 3 clk after each falling edge.
- Force pat_idx=2 (entry 2, reverse speed 3) with scroll_x=1, then one tick -> scroll_x=1022. With NUM_PATTERNS=3, an advance from idx 2 -> pat_idx=0.
- pause=1 for 3 ticks from scroll_x=10, dwell=1 -> scroll_x stays 10 and dwell stays 1. Release pause -> next tick scroll_x=11, dwell=2.
- auto_en=0, three step pulses within one frame -> exactly one advance (0->1) at the next tick; the following tick without a step leaves pat_idx=1.
- pause=1 plus one step pulse -> pat_idx advances 0->1 and r_sel=4, while scroll_x is unchanged.
